branch_comp_iter: RTL
=====================

Name: branch_comp_iter

Overview:
Parametrised, iterative branch comparator for the RISC-V core. It resolves all six conditional-branch funct3 encodings over a valid/ready handshake, producing taken/breq/brlt for the branch unit. Operands are compared MSB-first in CHUNK-bit slices, so the width and the area/latency trade-off are set at elaboration. It replaces the single-cycle eq/lt comparator where a narrow, multi-cycle datapath is wanted.

Parameters:
WIDTH, 32, operand width in bits.
CHUNK, 8, bits compared per cycle. Must divide WIDTH. N = WIDTH/CHUNK; CHUNK==WIDTH gives N=1.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  request valid.
in_ready  out  1  block can accept; equals (state==IDLE).
funct3  in  3  branch funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
rs1  in  WIDTH  operand 1.
rs2  in  WIDTH  operand 2.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
taken  out  1  branch condition true.
breq  out  1  rs1==rs2.
brlt  out  1  rs1<rs2; signed if funct3[1]==0, unsigned otherwise.
illegal  out  1  funct3 is 010 or 011.

Behaviour:
- Reset (async, rst_n low): state=IDLE; out_valid, taken, breq, brlt, illegal = 0; in_ready=1; captured operands, funct3 and chunk index cleared.
- FSM states: IDLE, CMP, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture rs1, rs2 and funct3. If funct3 is illegal, go to DONE with illegal=1, taken=0, breq=0, brlt=0. Otherwise go to CMP with idx=N-1, eq_acc=1.
- CMP: each cycle compares slice idx (bits idx*CHUNK+CHUNK-1 : idx*CHUNK).
  - Top slice (idx==N-1) is compared signed when funct3[1]==0. All other slices, and every slice in unsigned mode, are compared unsigned.
  - Slices differ: brlt = slice lt, breq=0, go to DONE (early exit, default build).
  - Slices equal and idx==0: breq=1, brlt=0, go to DONE.
  - Slices equal and idx>0: idx decrements; stay in CMP.
- taken, set on the transition into DONE:
  - BEQ: breq
  - BNE: !breq
  - BLT, BLTU: brlt
  - BGE, BGEU: !brlt
- Latency, accept edge to out_valid high:
  - illegal funct3: 1 cycle.
  - legal, early exit: k cycles, where k = 1 + number of equal leading slices. Maximum N.
  - legal, equal operands: N cycles.
- DONE: out_valid=1. Outputs are registered and held stable until out_ready. On out_valid&&out_ready: out_valid=0, state=IDLE. in_ready=0 in DONE, so there is no same-cycle re-accept; minimum issue interval is latency+1.
- in_valid during CMP or DONE is ignored; the upstream stage must hold it.
- rst_n low mid-CMP or mid-DONE: operation aborts, no out_valid pulse, IDLE on release.
- N==1: CMP lasts exactly one cycle; the only slice is the top slice.
- Elaboration error if WIDTH % CHUNK != 0 or CHUNK < 1.

Optional Feature:
BRANCH_COMP_EARLY_EXIT_EN
- Defined (default build): CMP exits on the first differing slice, as above.
- Undefined: CMP always runs all N slices. The decision latches at the first differing slice and later slices are ignored. Latency is a constant N cycles for legal funct3; illegal funct3 stays at 1 cycle.

Test Plan:
All tests use WIDTH=32, CHUNK=8, N=4, out_ready=1 unless stated.
1. BEQ, rs1=rs2=0xDEADBEEF -> out_valid 4 cycles after accept; taken=1, breq=1, brlt=0.
2. BLT, rs1=0xFFFFFFFF, rs2=0x00000001 -> taken=1, brlt=1, latency 1 (early exit). Same operands with BLTU -> taken=0, brlt=0, latency 1. Without BRANCH_COMP_EARLY_EXIT_EN, both take 4 cycles with the same results.
3. BGEU, rs1=0x12345600, rs2=0x12345601 -> differ in slice 0; taken=0, brlt=1, breq=0, latency 4. BNE on the same operands -> taken=1.
4. funct3=3'b010, any operands -> illegal=1, taken=0, out_valid 1 cycle after accept. funct3=3'b011 gives the same.
5. BGE, rs1=0x80000000, rs2=0x7FFFFFFF, out_ready low for 5 cycles -> taken=0, brlt=1. Outputs and out_valid stay stable and in_ready=0 throughout. After the handshake, in_ready=1 and the next request is accepted.
6. Accept BEQ with equal operands, then assert rst_n low in the 2nd CMP cycle -> no out_valid, all outputs 0. On release in_ready=1, and a fresh BNE with rs1=1, rs2=2 gives taken=1 at latency 4.

Source files
------------

// File: rtl/branch_comp_iter_if.sv
// branch_comp_iter_if: request/result handshake bundle for the iterative branch comparator.
interface branch_comp_iter_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic             breq;
  logic             brlt;
  logic             illegal;
  modport master (
    output in_valid, funct3, rs1, rs2, out_ready,
    input  in_ready, out_valid, taken, breq, brlt, illegal
  );
  modport slave (
    input  in_valid, funct3, rs1, rs2, out_ready,
    output in_ready, out_valid, taken, breq, brlt, illegal
  );
endinterface

// File: rtl/branch_comp_iter.sv
// branch_comp_iter: MSB-first CHUNK-bit iterative branch comparator (BEQ/BNE/BLT/BGE/BLTU/BGEU).
// BRANCH_COMP_EARLY_EXIT_EN: leave CMP at the first differing slice instead of scanning all N.
module branch_comp_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic              clk,
  input logic              rst_n,
  branch_comp_iter_if.slave bus
);
  localparam int CK = (CHUNK < 1) ? 1 : CHUNK;
  localparam int N  = WIDTH / CK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if (CHUNK < 1 || WIDTH % CK != 0) begin : g_bad_cfg
      $error("branch_comp_iter: CHUNK must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    idx, idx_nx;
  logic [WIDTH-1:0] a, a_nx, b, b_nx;
  logic [2:0]       f3, f3_nx;
  logic             taken, taken_nx, breq, breq_nx, brlt, brlt_nx, illegal, illegal_nx;
  logic [CK-1:0]    sa, sb, msk;
  logic             sgn, slt, sdiff, bad;
`ifndef BRANCH_COMP_EARLY_EXIT_EN
  logic             eq_acc, eq_acc_nx, lt_acc, lt_acc_nx, fin_eq, fin_lt;
`endif

  function automatic logic resolve(input logic [2:0] f, input logic eq, input logic lt);
    return f[2] ? (lt ^ f[0]) : (eq ^ f[0]);
  endfunction

  assign bad = bus.funct3[2:1] == 2'b01;
  assign sa  = a[int'(idx)*CK +: CK];
  assign sb  = b[int'(idx)*CK +: CK];
  // Flipping the slice MSB turns a signed compare of the top slice into an unsigned one.
  assign sgn   = (idx == IW'(N-1)) && !f3[1];
  assign msk   = CK'(sgn) << (CK-1);
  assign slt   = (sa ^ msk) < (sb ^ msk);
  assign sdiff = sa != sb;
`ifndef BRANCH_COMP_EARLY_EXIT_EN
  assign fin_eq = eq_acc && !sdiff;
  assign fin_lt = eq_acc ? slt : lt_acc;
`endif

  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.taken     = taken;
  assign bus.breq      = breq;
  assign bus.brlt      = brlt;
  assign bus.illegal   = illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a       <= '0;
      b       <= '0;
      f3      <= '0;
      taken   <= 1'b0;
      breq    <= 1'b0;
      brlt    <= 1'b0;
      illegal <= 1'b0;
`ifndef BRANCH_COMP_EARLY_EXIT_EN
      eq_acc  <= 1'b1;
      lt_acc  <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      a       <= a_nx;
      b       <= b_nx;
      f3      <= f3_nx;
      taken   <= taken_nx;
      breq    <= breq_nx;
      brlt    <= brlt_nx;
      illegal <= illegal_nx;
`ifndef BRANCH_COMP_EARLY_EXIT_EN
      eq_acc  <= eq_acc_nx;
      lt_acc  <= lt_acc_nx;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    a_nx       = a;
    b_nx       = b;
    f3_nx      = f3;
    taken_nx   = taken;
    breq_nx    = breq;
    brlt_nx    = brlt;
    illegal_nx = illegal;
`ifndef BRANCH_COMP_EARLY_EXIT_EN
    eq_acc_nx  = eq_acc;
    lt_acc_nx  = lt_acc;
`endif
    case (state)
      IDLE: if (bus.in_valid) begin
        a_nx       = bus.rs1;
        b_nx       = bus.rs2;
        f3_nx      = bus.funct3;
        idx_nx     = IW'(N-1);
        illegal_nx = bad;
        taken_nx   = 1'b0;
        breq_nx    = 1'b0;
        brlt_nx    = 1'b0;
        state_nx   = bad ? DONE : CMP;
`ifndef BRANCH_COMP_EARLY_EXIT_EN
        eq_acc_nx  = 1'b1;
        lt_acc_nx  = 1'b0;
`endif
      end
      CMP: begin
`ifdef BRANCH_COMP_EARLY_EXIT_EN
        if (sdiff) begin
          breq_nx  = 1'b0;
          brlt_nx  = slt;
          taken_nx = resolve(f3, 1'b0, slt);
          state_nx = DONE;
        end else if (idx == '0) begin
          breq_nx  = 1'b1;
          brlt_nx  = 1'b0;
          taken_nx = resolve(f3, 1'b1, 1'b0);
          state_nx = DONE;
        end else begin
          idx_nx   = idx - 1'b1;
        end
`else
        // The verdict is frozen at the first differing slice; later slices only burn cycles.
        if (eq_acc && sdiff) begin
          eq_acc_nx = 1'b0;
          lt_acc_nx = slt;
        end
        if (idx == '0) begin
          breq_nx  = fin_eq;
          brlt_nx  = fin_lt;
          taken_nx = resolve(f3, fin_eq, fin_lt);
          state_nx = DONE;
        end else begin
          idx_nx   = idx - 1'b1;
        end
`endif
      end
      DONE: state_nx = bus.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
endmodule
